// File: rtl/d_phy_mc_lane_ctrl_pkg.sv
// rtl/d_phy_mc_lane_ctrl_pkg.sv - line-state codes, FSM states, error codes and default timings
package d_phy_mc_lane_ctrl_pkg;

  localparam int LINE_W = 3;

  typedef enum logic [LINE_W-1:0] {
    LINE_OFF   = 3'd0,
    LINE_LP00  = 3'd1,
    LINE_LP01  = 3'd2,
    LINE_LP10  = 3'd3,
    LINE_LP11  = 3'd4,
    LINE_HS0   = 3'd5,
    LINE_HS1   = 3'd6,
    LINE_MARK1 = 3'd7
  } t_phy_line_states;

  typedef enum logic [4:0] {
    ST_OFF, ST_INIT, ST_STOP,
    ST_HS_LPX, ST_HS_PREP, ST_HS_ZERO, ST_HS_PRE, ST_HS_TX,
    ST_HS_POST, ST_HS_TRAIL, ST_HS_EXIT,
    ST_ULPS_LPX, ST_ULPS, ST_ULPS_WAKE,
    ST_IDLE_POST, ST_IDLE, ST_IDLE_PRE,
    ST_ERROR
  } t_mc_state;

  typedef enum logic [2:0] {
    ERR_NONE, ERR_MUTEX, ERR_STARTUP, ERR_GAP, ERR_ULPS, ERR_IDLE
  } t_mc_err;

  localparam int DEF_CNT_W             = 16;
  localparam int DEF_WORD_UI           = 8;
  localparam int DEF_T_INIT_CYC        = 1000;
  localparam int DEF_T_LPX_CYC         = 50;
  localparam int DEF_T_CLK_PREPARE_CYC = 40;
  localparam int DEF_T_CLK_ZERO_CYC    = 260;
  localparam int DEF_T_CLK_PRE_UI      = 8;
  localparam int DEF_T_CLK_POST_UI     = 68;
  localparam int DEF_T_CLK_TRAIL_CYC   = 60;
  localparam int DEF_T_HS_EXIT_CYC     = 100;
  localparam int DEF_T_HS_IDLE_POST_UI = 8;
  localparam int DEF_T_HS_IDLE_PRE_UI  = 8;
  localparam int DEF_T_HS_IDLE_HS0_CYC = 64;
  localparam int DEF_T_WAKEUP_CYC      = 1000;

  // States in which the word counter runs (toggling or HS idle).
  function automatic logic is_clocking(input t_mc_state s);
    return (s == ST_HS_PRE) || (s == ST_HS_TX) || (s == ST_HS_POST) ||
           (s == ST_IDLE_POST) || (s == ST_IDLE) || (s == ST_IDLE_PRE);
  endfunction

endpackage

// File: rtl/d_phy_mc_lane_ctrl_if.sv
// rtl/d_phy_mc_lane_ctrl_if.sv - PPI request/status bundle between CSI Tx and the clock-lane controller
interface d_phy_mc_lane_ctrl_if;
  import d_phy_mc_lane_ctrl_pkg::*;

  logic             enable;
  logic             tx_request_hs;
  logic             tx_ulps_clk;
  logic             tx_ulps_exit;
  logic             tx_hs_idle_clk_hs;
  logic             stopstate;
  logic             tx_ready_hs;
  logic             tx_hs_idle_clk_ready_hs;
  logic             ulps_active_not;
  logic             word_stb;
  t_phy_line_states line;
  logic             err;
  t_mc_err          err_code;

  modport master (
    output enable, tx_request_hs, tx_ulps_clk, tx_ulps_exit, tx_hs_idle_clk_hs,
    input  stopstate, tx_ready_hs, tx_hs_idle_clk_ready_hs, ulps_active_not,
           word_stb, line, err, err_code
  );

  modport slave (
    input  enable, tx_request_hs, tx_ulps_clk, tx_ulps_exit, tx_hs_idle_clk_hs,
    output stopstate, tx_ready_hs, tx_hs_idle_clk_ready_hs, ulps_active_not,
           word_stb, line, err, err_code
  );

endinterface

// File: rtl/d_phy_mc_lane_ctrl_ui_timer.sv
// rtl/d_phy_mc_lane_ctrl_ui_timer.sv - load/decrement/done UI counter shared by all timed states
module d_phy_mc_lane_ctrl_ui_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/d_phy_mc_lane_ctrl.sv
// rtl/d_phy_mc_lane_ctrl.sv - D-PHY master clock-lane controller (init/stop/HS clock/ULPS)
// HS Tx Idle states are built only when D_PHY_MC_HS_IDLE_EN is defined.
module d_phy_mc_lane_ctrl
  import d_phy_mc_lane_ctrl_pkg::*;
#(
  parameter int CNT_W             = DEF_CNT_W,
  parameter int WORD_UI           = DEF_WORD_UI,
  parameter int T_INIT_CYC        = DEF_T_INIT_CYC,
  parameter int T_LPX_CYC         = DEF_T_LPX_CYC,
  parameter int T_CLK_PREPARE_CYC = DEF_T_CLK_PREPARE_CYC,
  parameter int T_CLK_ZERO_CYC    = DEF_T_CLK_ZERO_CYC,
  parameter int T_CLK_PRE_UI      = DEF_T_CLK_PRE_UI,
  parameter int T_CLK_POST_UI     = DEF_T_CLK_POST_UI,
  parameter int T_CLK_TRAIL_CYC   = DEF_T_CLK_TRAIL_CYC,
  parameter int T_HS_EXIT_CYC     = DEF_T_HS_EXIT_CYC,
  parameter int T_HS_IDLE_POST_UI = DEF_T_HS_IDLE_POST_UI,
  parameter int T_HS_IDLE_PRE_UI  = DEF_T_HS_IDLE_PRE_UI,
  parameter int T_HS_IDLE_HS0_CYC = DEF_T_HS_IDLE_HS0_CYC,
  parameter int T_WAKEUP_CYC      = DEF_T_WAKEUP_CYC
) (
  input logic                 hs_clk,
  input logic                 rst,
  d_phy_mc_lane_ctrl_if.slave ppi
);

  if (WORD_UI == 0 || T_INIT_CYC == 0 || T_LPX_CYC == 0 || T_CLK_PREPARE_CYC == 0 ||
      T_CLK_ZERO_CYC == 0 || T_CLK_PRE_UI == 0 || T_CLK_POST_UI == 0 ||
      T_CLK_TRAIL_CYC == 0 || T_HS_EXIT_CYC == 0 || T_HS_IDLE_POST_UI == 0 ||
      T_HS_IDLE_PRE_UI == 0 || T_HS_IDLE_HS0_CYC == 0 || T_WAKEUP_CYC == 0) begin : g_bad_timing
    $fatal(1, "d_phy_mc_lane_ctrl: timing parameters must be non-zero");
  end

  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_UI - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  t_mc_state        state, nxt;
  t_mc_err          code, err_code_q;
  t_phy_line_states line_q, tog;
  logic             err_q, stopstate_q, tx_ready_q, idle_ready_q, uan_q, word_stb_q;
  logic [CNT_W-1:0] wcnt, wcnt_inc, wcnt_nxt, tmr_val;
  logic             tmr_done, tmr_load, stb_nxt, idle_bad;
  logic             req, ulps, idle;

  assign req  = ppi.tx_request_hs;
  assign ulps = ppi.tx_ulps_clk;
  assign idle = ppi.tx_hs_idle_clk_hs;
  assign tog  = (line_q == LINE_HS1) ? LINE_HS0 : LINE_HS1;

  assign wcnt_inc = (wcnt == WORD_LAST) ? '0 : wcnt + ONE;

  always_comb begin
    nxt      = state;
    code     = ERR_NONE;
    idle_bad = 1'b0;
`ifndef D_PHY_MC_HS_IDLE_EN
    idle_bad = idle && (state != ST_OFF) && (state != ST_ERROR);
`endif
    if (!ppi.enable) begin
      nxt = ST_OFF;
    end else if (idle_bad) begin
      nxt  = ST_ERROR;
      code = ERR_IDLE;
    end else begin
      case (state)
        ST_OFF:  nxt = ST_INIT;
        ST_INIT: if (tmr_done) nxt = ST_STOP;
        ST_STOP: begin
          if (req && ulps) begin
            nxt  = ST_ERROR;
            code = ERR_MUTEX;
          end else if (req) begin
            nxt = ST_HS_LPX;
          end else if (ulps) begin
            nxt = ST_ULPS_LPX;
          end
        end
        ST_HS_LPX, ST_HS_PREP, ST_HS_ZERO, ST_HS_PRE: begin
          if (!req) begin
            nxt  = ST_ERROR;
            code = ERR_STARTUP;
          end else if (tmr_done) begin
            case (state)
              ST_HS_LPX:  nxt = ST_HS_PREP;
              ST_HS_PREP: nxt = ST_HS_ZERO;
              ST_HS_ZERO: nxt = ST_HS_PRE;
              default:    nxt = ST_HS_TX;
            endcase
          end
        end
        ST_HS_TX: begin
          if (!req && idle) begin
            nxt  = ST_ERROR;
            code = ERR_MUTEX;
          end else if (!req) begin
            nxt = ST_HS_POST;
          end
`ifdef D_PHY_MC_HS_IDLE_EN
          else if (idle) begin
            nxt = ST_IDLE_POST;
          end
`endif
        end
        ST_HS_POST, ST_HS_TRAIL, ST_HS_EXIT: begin
          if (req) begin
            nxt  = ST_ERROR;
            code = ERR_GAP;
          end else if (tmr_done) begin
            // the post toggle burst must finish on an HS0 UI
            if (state == ST_HS_POST && line_q == LINE_HS0) nxt = ST_HS_TRAIL;
            else if (state == ST_HS_TRAIL)                 nxt = ST_HS_EXIT;
            else if (state == ST_HS_EXIT)                  nxt = ST_STOP;
          end
        end
        ST_ULPS_LPX, ST_ULPS: begin
          if (!ulps) begin
            nxt  = ST_ERROR;
            code = ERR_ULPS;
          end else if (state == ST_ULPS_LPX && tmr_done) begin
            nxt = ST_ULPS;
          end else if (state == ST_ULPS && ppi.tx_ulps_exit) begin
            nxt = ST_ULPS_WAKE;
          end
        end
        ST_ULPS_WAKE: begin
          if (tmr_done) begin
            if (!ulps) nxt = ST_STOP;
          end else if (!ulps) begin
            nxt  = ST_ERROR;
            code = ERR_ULPS;
          end
        end
`ifdef D_PHY_MC_HS_IDLE_EN
        ST_IDLE_POST: if (tmr_done && line_q == LINE_HS0) nxt = ST_IDLE;
        ST_IDLE: begin
          if (!idle) begin
            if (tmr_done) begin
              nxt = ST_IDLE_PRE;
            end else begin
              nxt  = ST_ERROR;
              code = ERR_IDLE;
            end
          end
        end
        ST_IDLE_PRE: if (tmr_done && wcnt_inc == WORD_LAST) nxt = ST_HS_TX;
`endif
        ST_ERROR: nxt = ST_ERROR;
        default:  nxt = ST_OFF;
      endcase
    end
  end

  always_comb begin
    tmr_load = (nxt != state);
    case (nxt)
      ST_INIT:                tmr_val = CNT_W'(T_INIT_CYC - 1);
      ST_HS_LPX, ST_ULPS_LPX: tmr_val = CNT_W'(T_LPX_CYC - 1);
      ST_HS_PREP:             tmr_val = CNT_W'(T_CLK_PREPARE_CYC - 1);
      ST_HS_ZERO:             tmr_val = CNT_W'(T_CLK_ZERO_CYC - 1);
      ST_HS_PRE:              tmr_val = CNT_W'(T_CLK_PRE_UI - 1);
      ST_HS_POST:             tmr_val = CNT_W'(T_CLK_POST_UI - 1);
      ST_HS_TRAIL:            tmr_val = CNT_W'(T_CLK_TRAIL_CYC - 1);
      ST_HS_EXIT:             tmr_val = CNT_W'(T_HS_EXIT_CYC - 1);
      ST_ULPS_WAKE:           tmr_val = CNT_W'(T_WAKEUP_CYC - 1);
      ST_IDLE_POST:           tmr_val = CNT_W'(T_HS_IDLE_POST_UI - 1);
      ST_IDLE:                tmr_val = CNT_W'(T_HS_IDLE_HS0_CYC - 1);
      ST_IDLE_PRE:            tmr_val = CNT_W'(T_HS_IDLE_PRE_UI - 1);
      default:                tmr_val = '0;
    endcase
  end

  // Word phase restarts at HS0 so word_stb lines up with the first toggle burst.
  always_comb begin
    if (nxt == ST_HS_ZERO)    wcnt_nxt = '0;
    else if (is_clocking(nxt)) wcnt_nxt = wcnt_inc;
    else                       wcnt_nxt = wcnt;
    stb_nxt = is_clocking(nxt) && (wcnt_inc == WORD_LAST);
  end

  d_phy_mc_lane_ctrl_ui_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (hs_clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge hs_clk) begin
    if (rst) begin
      state        <= ST_OFF;
      line_q       <= LINE_OFF;
      stopstate_q  <= 1'b0;
      tx_ready_q   <= 1'b0;
      idle_ready_q <= 1'b0;
      uan_q        <= 1'b1;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
      word_stb_q   <= 1'b0;
      wcnt         <= '0;
    end else begin
      state       <= nxt;
      wcnt        <= wcnt_nxt;
      word_stb_q  <= stb_nxt;
      stopstate_q <= (nxt == ST_STOP);
      uan_q       <= (nxt != ST_ULPS);

      case (nxt)
        ST_INIT, ST_STOP, ST_HS_EXIT:    line_q <= LINE_LP11;
        ST_HS_LPX:                       line_q <= LINE_LP01;
        ST_HS_PREP, ST_ULPS:             line_q <= LINE_LP00;
        ST_ULPS_LPX:                     line_q <= LINE_LP10;
        ST_HS_ZERO, ST_HS_TRAIL, ST_IDLE: line_q <= LINE_HS0;
        ST_ULPS_WAKE:                    line_q <= LINE_MARK1;
        ST_HS_PRE, ST_HS_TX, ST_HS_POST,
        ST_IDLE_POST, ST_IDLE_PRE:       line_q <= tog;
        default:                         line_q <= LINE_OFF;
      endcase

      case (nxt)
        ST_HS_TX:                  tx_ready_q <= tx_ready_q | stb_nxt;
        ST_HS_POST, ST_IDLE:       tx_ready_q <= tx_ready_q & ~stb_nxt;
        ST_IDLE_POST, ST_IDLE_PRE: tx_ready_q <= tx_ready_q;
        default:                   tx_ready_q <= 1'b0;
      endcase

      case (nxt)
        ST_IDLE:     idle_ready_q <= idle_ready_q | ((state == ST_IDLE) && tmr_done && stb_nxt);
        ST_IDLE_PRE: idle_ready_q <= idle_ready_q;
        default:     idle_ready_q <= 1'b0;
      endcase

      if (nxt == ST_ERROR && !err_q) begin
        err_q      <= 1'b1;
        err_code_q <= code;
      end
    end
  end

  assign ppi.line                    = line_q;
  assign ppi.stopstate               = stopstate_q;
  assign ppi.tx_ready_hs             = tx_ready_q;
  assign ppi.tx_hs_idle_clk_ready_hs = idle_ready_q;
  assign ppi.ulps_active_not         = uan_q;
  assign ppi.word_stb                = word_stb_q;
  assign ppi.err                     = err_q;
  assign ppi.err_code                = err_code_q;

endmodule

// File: tb/tb_d_phy_mc_lane_ctrl.sv
// tb/tb_d_phy_mc_lane_ctrl.sv - directed self-checking bench for the D-PHY clock-lane controller
module tb_d_phy_mc_lane_ctrl;
  import d_phy_mc_lane_ctrl_pkg::*;

  logic hs_clk = 1'b0;
  logic rst    = 1'b1;
  int   checks = 0;
  int   errors = 0;

  d_phy_mc_lane_ctrl_if ppi();

  d_phy_mc_lane_ctrl dut (
    .hs_clk (hs_clk),
    .rst    (rst),
    .ppi    (ppi)
  );

  always #5 hs_clk = ~hs_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge hs_clk);
      #1;
    end
  endtask

  task automatic run_len(input t_phy_line_states code, input int limit, output int n);
    n = 0;
    while (ppi.line == code && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic idle_inputs();
    ppi.tx_request_hs     = 1'b0;
    ppi.tx_ulps_clk       = 1'b0;
    ppi.tx_ulps_exit      = 1'b0;
    ppi.tx_hs_idle_clk_hs = 1'b0;
  endtask

  task automatic reset_to_stop();
    idle_inputs();
    ppi.enable = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1001);
    check("rst_stop", ppi.stopstate, 1);
  endtask

  // Toggle UI index 1 is the first HS1; drop_idx is the UI after which req falls.
  task automatic hs_burst(input int drop_idx, input int exp_tail);
    int n, idx, first_stb, fall;
    ppi.tx_request_hs = 1'b1;
    tick();
    check("hs_lpx_line", ppi.line, LINE_LP01);
    check("hs_lpx_stop", ppi.stopstate, 0);
    run_len(LINE_LP01, 2000, n); check("lp01_len", n, 50);
    run_len(LINE_LP00, 2000, n); check("lp00_len", n, 40);
    run_len(LINE_HS0, 2000, n);  check("hs0_len", n, 260);
    check("first_ui_hs1", ppi.line, LINE_HS1);
    idx = 1;
    first_stb = 0;
    while (!ppi.tx_ready_hs && idx < 100) begin
      if (ppi.word_stb && first_stb == 0) first_stb = idx;
      tick();
      idx++;
    end
    check("first_stb_ui", first_stb, 7);
    check("ready_ui", idx, 15);
    check("ready_on_stb", ppi.word_stb, 1);
    tick(drop_idx - idx);
    ppi.tx_request_hs = 1'b0;
    n = 0;
    fall = 0;
    while (ppi.line != LINE_LP11 && n < 1000) begin
      tick();
      n++;
      if (!ppi.tx_ready_hs && fall == 0) fall = n;
    end
    check("post_trail_len", n, exp_tail);
    check("ready_fall", fall, 47 - drop_idx);
    n = 0;
    while (ppi.line == LINE_LP11 && !ppi.stopstate && n < 1000) begin
      tick();
      n++;
    end
    check("hs_exit_len", n, 100);
    check("hs_back_stop", ppi.stopstate, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle_inputs();
    ppi.enable = 1'b1;
    rst = 1'b1;
    tick(2);
    check("rst_line", ppi.line, LINE_OFF);
    check("rst_stop", ppi.stopstate, 0);
    check("rst_ready", ppi.tx_ready_hs, 0);
    check("rst_idle_ready", ppi.tx_hs_idle_clk_ready_hs, 0);
    check("rst_uan", ppi.ulps_active_not, 1);
    check("rst_err", ppi.err, 0);
    check("rst_code", ppi.err_code, ERR_NONE);
    check("rst_stb", ppi.word_stb, 0);
    rst = 1'b0;
    tick();
    check("init_line", ppi.line, LINE_LP11);
    check("init_stop", ppi.stopstate, 0);
    tick(999);
    check("init_last", ppi.stopstate, 0);
    tick();
    check("init_done", ppi.stopstate, 1);
    check("stop_line", ppi.line, LINE_LP11);

    hs_burst(40, 129);
    hs_burst(39, 130);

    ppi.tx_ulps_clk = 1'b1;
    tick();
    check("ulps_lpx_line", ppi.line, LINE_LP10);
    run_len(LINE_LP10, 2000, n);
    check("lp10_len", n, 50);
    check("ulps_line", ppi.line, LINE_LP00);
    check("ulps_uan", ppi.ulps_active_not, 0);
    tick(449);
    check("ulps_hold", ppi.line, LINE_LP00);
    ppi.tx_ulps_exit = 1'b1;
    tick();
    ppi.tx_ulps_exit = 1'b0;
    check("wake_line", ppi.line, LINE_MARK1);
    check("wake_uan", ppi.ulps_active_not, 1);
    tick(1099);
    check("wake_hold", ppi.line, LINE_MARK1);
    ppi.tx_ulps_clk = 1'b0;
    tick();
    check("wake_stop", ppi.stopstate, 1);
    check("wake_lp11", ppi.line, LINE_LP11);

    ppi.tx_request_hs = 1'b1;
    tick(353);
    check("pre_ui3", ppi.line, LINE_HS1);
    ppi.enable = 1'b0;
    tick();
    check("off_line", ppi.line, LINE_OFF);
    check("off_ready", ppi.tx_ready_hs, 0);
    check("off_stb", ppi.word_stb, 0);
    check("off_uan", ppi.ulps_active_not, 1);
    check("off_err", ppi.err, 0);
    ppi.tx_request_hs = 1'b0;
    ppi.enable = 1'b1;
    tick();
    check("reinit_line", ppi.line, LINE_LP11);
    check("reinit_stop", ppi.stopstate, 0);
    tick(1000);
    check("reinit_done", ppi.stopstate, 1);

    ppi.tx_request_hs = 1'b1;
    ppi.tx_ulps_clk = 1'b1;
    tick();
    check("mutex_err", ppi.err, 1);
    check("mutex_code", ppi.err_code, ERR_MUTEX);
    check("mutex_line", ppi.line, LINE_OFF);
    idle_inputs();
    tick(20);
    check("error_hold", ppi.line, LINE_OFF);
    ppi.enable = 1'b0;
    tick();
    check("err_sticky", ppi.err, 1);
    ppi.enable = 1'b1;
    tick(1001);
    check("err_reinit", ppi.stopstate, 1);
    ppi.tx_request_hs = 1'b1;
    tick(60);
    ppi.tx_request_hs = 1'b0;
    tick();
    check("code_latched", ppi.err_code, ERR_MUTEX);

    reset_to_stop();
    check("rst_clears_err", ppi.err, 0);
    ppi.tx_request_hs = 1'b1;
    tick(60);
    ppi.tx_request_hs = 1'b0;
    tick();
    check("startup_code", ppi.err_code, ERR_STARTUP);
    check("startup_line", ppi.line, LINE_OFF);

    reset_to_stop();
    ppi.tx_request_hs = 1'b1;
    tick(371);
    ppi.tx_request_hs = 1'b0;
    tick(5);
    ppi.tx_request_hs = 1'b1;
    tick();
    check("gap_code", ppi.err_code, ERR_GAP);

    reset_to_stop();
    ppi.tx_ulps_clk = 1'b1;
    tick(10);
    ppi.tx_ulps_clk = 1'b0;
    tick();
    check("ulps_code", ppi.err_code, ERR_ULPS);

`ifdef D_PHY_MC_HS_IDLE_EN
    reset_to_stop();
    ppi.tx_request_hs = 1'b1;
    tick(365);
    check("idle_pre_ready", ppi.tx_ready_hs, 1);
    tick();
    ppi.tx_hs_idle_clk_hs = 1'b1;
    tick(40);
    ppi.tx_hs_idle_clk_hs = 1'b0;
    tick();
    check("idle_short_code", ppi.err_code, ERR_IDLE);

    reset_to_stop();
    ppi.tx_request_hs = 1'b1;
    tick(366);
    ppi.tx_hs_idle_clk_hs = 1'b1;
    tick();
    check("idle_post_ui", ppi.line, LINE_HS1);
    tick(199);
    check("idle_ready", ppi.tx_hs_idle_clk_ready_hs, 1);
    check("idle_tx_ready", ppi.tx_ready_hs, 0);
    check("idle_line", ppi.line, LINE_HS0);
    ppi.tx_hs_idle_clk_hs = 1'b0;
    n = 0;
    while (!ppi.tx_ready_hs && n < 100) begin
      tick();
      n++;
    end
    check("idle_exit_len", n, 15);
    check("idle_exit_ready", ppi.tx_hs_idle_clk_ready_hs, 0);
    check("idle_exit_stb", ppi.word_stb, 1);
`else
    reset_to_stop();
    ppi.tx_hs_idle_clk_hs = 1'b1;
    tick();
    check("idle_code", ppi.err_code, ERR_IDLE);
    check("idle_line", ppi.line, LINE_OFF);
    check("idle_ready_tied", ppi.tx_hs_idle_clk_ready_hs, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
